// File: rtl/sr_flipflop_gate_pkg.sv
// Shared helpers for the gate-level SR flip-flop: input gating terms that feed
// the master stage, written as pure AND/OR/NOT expressions.
package sr_flipflop_gate_pkg;

  // Collapse S=R=1 into "no request" so no latch ever sees a forbidden input.
  function automatic logic set_only(input logic s, input logic r);
    return s & ~r;
  endfunction

  // Master request line: during rst the request is forced to the reset value,
  // otherwise it follows the gated S/R request.
  function automatic logic rst_gate(input logic rst, input logic req, input logic rst_val);
    return (~rst & req) | (rst & rst_val);
  endfunction

endpackage

// File: rtl/sr_latch_nand.sv
// Cross-coupled NAND SR latch with active-low set/reset.
// s_n=0 -> q=1, r_n=0 -> q=0, both high -> hold. Both low is never driven by
// the surrounding gating, so qn is kept as the strict complement of q.
module sr_latch_nand (
  input  logic s_n,
  input  logic r_n,
  output logic q,
  output logic qn
);

  logic r_q;

  // Storage node of the NAND pair: level-sensitive set/reset, otherwise hold
  always_latch begin
    if (!s_n) begin
      r_q <= 1'b1;
    end else if (!r_n) begin
      r_q <= 1'b0;
    end
  end

  assign q  = r_q;
  assign qn = ~r_q;

endmodule

// File: rtl/sr_flipflop_gate.sv
// Gate-level rising-edge SR flip-flop, WIDTH independent bits.
//
// Each bit is a master-slave pair built from NAND SR latches:
//   - master: two gated NAND latches holding the "set request" and the
//     "reset request". They are transparent while clk is low and track the
//     gated inputs in both directions, so a pulse on S or R that is gone
//     before the rising edge leaves nothing behind (no ones-catching).
//   - slave: one gated NAND latch, open while clk is high, which applies the
//     captured set/reset request. No request -> hold.
// S=R=1 is reduced to "no request" before the master, and rst overrides the
// master requests with RESET_Q, so reset takes effect only on a rising edge.
module sr_flipflop_gate
  import sr_flipflop_gate_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RESET_Q = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  logic [WIDTH-1:0] w_set_req;
  logic [WIDTH-1:0] w_rst_req;
  logic [WIDTH-1:0] w_ms_set_n;
  logic [WIDTH-1:0] w_ms_rst_n;
  logic [WIDTH-1:0] w_mr_set_n;
  logic [WIDTH-1:0] w_mr_rst_n;
  logic [WIDTH-1:0] w_ms_q;
  logic [WIDTH-1:0] w_ms_qn;
  logic [WIDTH-1:0] w_mr_q;
  logic [WIDTH-1:0] w_mr_qn;
  logic [WIDTH-1:0] w_sl_set_n;
  logic [WIDTH-1:0] w_sl_rst_n;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      // Input gating: invalid S=R=1 becomes no request; rst forces RESET_Q.
      assign w_set_req[i] = rst_gate(rst, set_only(S[i], R[i]),  RESET_Q[i]);
      assign w_rst_req[i] = rst_gate(rst, set_only(R[i], S[i]), ~RESET_Q[i]);

      // Master latches behave as D latches on the request lines, clk low.
      assign w_ms_set_n[i] = ~(~clk &  w_set_req[i]);
      assign w_ms_rst_n[i] = ~(~clk & ~w_set_req[i]);
      assign w_mr_set_n[i] = ~(~clk &  w_rst_req[i]);
      assign w_mr_rst_n[i] = ~(~clk & ~w_rst_req[i]);

      sr_latch_nand u_master_set (
        .s_n (w_ms_set_n[i]),
        .r_n (w_ms_rst_n[i]),
        .q   (w_ms_q[i]),
        .qn  (w_ms_qn[i])
      );

      sr_latch_nand u_master_rst (
        .s_n (w_mr_set_n[i]),
        .r_n (w_mr_rst_n[i]),
        .q   (w_mr_q[i]),
        .qn  (w_mr_qn[i])
      );

      // Slave applies the captured requests while clk is high; the two
      // requests are mutually exclusive by construction of the gating.
      assign w_sl_set_n[i] = ~(clk & w_ms_q[i] & w_mr_qn[i]);
      assign w_sl_rst_n[i] = ~(clk & w_mr_q[i] & w_ms_qn[i]);

      sr_latch_nand u_slave (
        .s_n (w_sl_set_n[i]),
        .r_n (w_sl_rst_n[i]),
        .q   (Q[i]),
        .qn  (Qbar[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sr_flipflop_gate.sv
// Directed bench for sr_flipflop_gate: a 1-bit instance with default
// parameters and a 4-bit instance with RESET_Q=4'b1010, driven side by side.
module tb_sr_flipflop_gate;

  logic       clk;
  logic       rst;
  logic       s1, r1;
  logic       q1, qb1;
  logic [3:0] s4, r4;
  logic [3:0] q4, qb4;

  int n_tests = 0;
  int n_fail  = 0;

  sr_flipflop_gate u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .S    (s1),
    .R    (r1),
    .Q    (q1),
    .Qbar (qb1)
  );

  sr_flipflop_gate #(
    .WIDTH   (4),
    .RESET_Q (4'b1010)
  ) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .S    (s4),
    .R    (r4),
    .Q    (q4),
    .Qbar (qb4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic exp_q);
    chk(tag, {3'b000, q1}, {3'b000, exp_q});
    chk({tag, "_qbar"}, {3'b000, qb1}, {3'b000, ~exp_q});
  endtask

  task automatic chk4(input string tag, input logic [3:0] exp_q);
    chk(tag, q4, exp_q);
    chk({tag, "_qbar"}, qb4, ~exp_q);
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s1 = 1'b1; r1 = 1'b0;
    s4 = 4'b1111; r4 = 4'b0000;

    // Reset wins over S=1
    edge_then_sample();
    chk1("reset_prio", 1'b0);
    chk4("reset_w4", 4'b1010);

    // Set; per-bit set/reset on the wide instance
    @(negedge clk);
    rst = 1'b0;
    s1 = 1'b1; r1 = 1'b0;
    s4 = 4'b0001; r4 = 4'b1000;
    edge_then_sample();
    chk1("set", 1'b1);
    chk4("sr_w4", 4'b0011);

    // Hold for two edges; S=R=1 on every wide bit holds
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
    s4 = 4'b1111; r4 = 4'b1111;
    edge_then_sample();
    chk1("hold1", 1'b1);
    chk4("invalid_w4", 4'b0011);
    edge_then_sample();
    chk1("hold2", 1'b1);
    chk4("invalid_w4_2", 4'b0011);

    // S=R=1 from Q=1
    @(negedge clk);
    s1 = 1'b1; r1 = 1'b1;
    s4 = 4'b0000; r4 = 4'b0000;
    edge_then_sample();
    chk1("invalid_from1", 1'b1);

    // Reset request
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b1;
    edge_then_sample();
    chk1("clear", 1'b0);

    // S=R=1 from Q=0
    @(negedge clk);
    s1 = 1'b1; r1 = 1'b1;
    edge_then_sample();
    chk1("invalid_from0", 1'b0);

    // S pulse entirely between edges: not sampled
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
    #1 s1 = 1'b1;
    #1 chk1("s_pulse_mid", 1'b0);
    #1 s1 = 1'b0;
    edge_then_sample();
    chk1("s_pulse_after_edge", 1'b0);

    // Set again, then pulse rst between edges
    @(negedge clk);
    s1 = 1'b1;
    edge_then_sample();
    chk1("set_again", 1'b1);
    @(negedge clk);
    s1 = 1'b0;
    #1 rst = 1'b1;
    #1 chk1("rst_pulse_mid", 1'b1);
    chk4("rst_pulse_mid_w4", 4'b0011);
    #1 rst = 1'b0;
    edge_then_sample();
    chk1("rst_pulse_after_edge", 1'b1);
    chk4("rst_pulse_after_edge_w4", 4'b0011);

    // rst high while clk is high: no edge, no change
    #1 rst = 1'b1;
    #1 chk1("rst_clk_high", 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Reset with conflicting S/R requests on both instances
    @(negedge clk);
    rst = 1'b1;
    s1 = 1'b1; r1 = 1'b0;
    s4 = 4'b0101; r4 = 4'b0000;
    edge_then_sample();
    chk1("reset_vs_set", 1'b0);
    chk4("reset_vs_set_w4", 4'b1010);

    // Wide: full rewrite
    @(negedge clk);
    rst = 1'b0;
    s1 = 1'b0; r1 = 1'b0;
    s4 = 4'b0101; r4 = 4'b1010;
    edge_then_sample();
    chk4("rewrite_w4", 4'b0101);

    // Wide: invalid on bit0 only, set on bit1, others hold
    @(negedge clk);
    s4 = 4'b0011; r4 = 4'b0001;
    edge_then_sample();
    chk4("indep_w4", 4'b0111);

    // Wide: clear bit2 and bit0 while bit3 sees S=R=1
    @(negedge clk);
    s4 = 4'b1000; r4 = 4'b1101;
    edge_then_sample();
    chk4("indep2_w4", 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
